sw_debounce: RTL and testbench

- Upstream input-conditioning stage for the 8-to-3 priority encoder / seven-segment path.
- Synchronises and debounces the raw board switches and the enable switch, then drives clean, stable x/en vectors into the encoder.
- Emits a one-cycle change pulse so downstream logic can react to new switch settings.

---
 rtl/sw_debounce.sv | 79 +++++++
 tb/tb_sw_debounce.sv | 105 ++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: synchronise and debounce board switches feeding the priority encoder.
//
// Build option: define SW_DEBOUNCE_BYPASS_EN to drop the stability counters for
// fast simulation (stab follows the synchroniser directly, busy tied low).
//
// Ports:
//   clk      - system clock, all state on rising edge
//   rst_n    - asynchronous active-low reset
//   sw_in    - raw bouncing data switches [WIDTH-1:0]
//   en_in    - raw bouncing enable switch
//   x_out    - debounced data switches (encoder x)
//   en_out   - debounced enable (encoder en)
//   changed  - one-cycle pulse when any bit of {en_out, x_out} takes a new value
//   busy     - high while any lane has a candidate change pending
module sw_debounce #(
   parameter int WIDTH         = 8,
   parameter int STABLE_CYCLES = 50000,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_in,
   input  logic             en_in,
   output logic [WIDTH-1:0] x_out,
   output logic             en_out,
   output logic             changed,
   output logic             busy
);
   // Counter peaks at STABLE_CYCLES-1 and must never wrap.
   generate
      if (STABLE_CYCLES < 1 || ((STABLE_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_cfg
         $error("sw_debounce: STABLE_CYCLES must be in 1 .. 2**CNT_W");
      end
   endgenerate
   // Lane WIDTH carries the enable switch; lanes below it carry sw_in.
   logic [WIDTH:0] raw, s1, s2, stab, stab_nxt;
   assign raw    = {en_in, sw_in};
   assign x_out  = stab[WIDTH-1:0];
   assign en_out = stab[WIDTH];
`ifdef SW_DEBOUNCE_BYPASS_EN
   assign stab_nxt = s2;
   assign busy     = 1'b0;
`else
   localparam logic [CNT_W-1:0] cnt_max = CNT_W'(STABLE_CYCLES - 1);
   logic [CNT_W-1:0] cnt [WIDTH+1];
   logic [CNT_W-1:0] cnt_nxt [WIDTH+1];
   // Any bounce back to the accepted value restarts the count from zero.
   always_comb begin
      stab_nxt = stab;
      busy     = 1'b0;
      for (int j = 0; j <= WIDTH; j++) begin
         cnt_nxt[j] = '0;
         if (s2[j] != stab[j]) begin
            if (cnt[j] == cnt_max) stab_nxt[j] = s2[j];
            else cnt_nxt[j] = cnt[j] + 1'b1;
         end
         busy = busy | (cnt[j] != '0);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '{default: '0};
      else cnt <= cnt_nxt;
   end
`endif
   // changed is registered alongside stab so it lines up with the new output value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1      <= '0;
         s2      <= '0;
         stab    <= '0;
         changed <= 1'b0;
      end else begin
         s1      <= raw;
         s2      <= s1;
         stab    <= stab_nxt;
         changed <= |(stab_nxt ^ stab);
      end
   end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed scoreboard bench for sw_debounce with STABLE_CYCLES=4.
module tb_sw_debounce;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] sw_in = 8'h00;
   logic       en_in = 1'b0;
   logic [7:0] x_out;
   logic       en_out, changed, busy;
   int vectors = 0;
   int miscompares = 0;
   typedef struct {
      string      tag;
      logic [7:0] x;
      logic       en;
      logic       ch;
      logic       busy;
   } exp_t;
   exp_t sb[$];
   sw_debounce #(.WIDTH(8), .STABLE_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .en_in(en_in),
      .x_out(x_out), .en_out(en_out), .changed(changed), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic check_out();
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL scoreboard_empty: got nothing, want an entry");
         return;
      end
      e = sb.pop_front();
      assert ({x_out, en_out, changed, busy} === {e.x, e.en, e.ch, e.busy}) else begin
         miscompares++;
         $error("FAIL %s: got x=%h en=%b ch=%b busy=%b, want x=%h en=%b ch=%b busy=%b",
                e.tag, x_out, en_out, changed, busy, e.x, e.en, e.ch, e.busy);
      end
   endtask
   task automatic chk(input string tag, input logic [7:0] ex, input logic een, ech, eb);
      sb.push_back('{tag, ex, een, ech, eb});
      check_out();
   endtask
   task automatic cyc(input logic [7:0] sw, input logic e, input logic [7:0] ex,
                      input logic een, ech, eb, input string tag);
      sw_in = sw;
      en_in = e;
      sb.push_back('{tag, ex, een, ech, eb});
      @(posedge clk);
      #1;
      check_out();
   endtask
   // Inputs move from old to new outputs and are held; edge 0 is the first sampling edge.
   task automatic xition(input logic [7:0] sw, input logic e, input logic [7:0] ox,
                         input logic oe, input string tag);
`ifdef SW_DEBOUNCE_BYPASS_EN
      cyc(sw, e, ox, oe, 1'b0, 1'b0, {tag, "_e0"});
      cyc(sw, e, ox, oe, 1'b0, 1'b0, {tag, "_e1"});
      cyc(sw, e, sw, e, 1'b1, 1'b0, {tag, "_e2"});
      cyc(sw, e, sw, e, 1'b0, 1'b0, {tag, "_e3"});
`else
      cyc(sw, e, ox, oe, 1'b0, 1'b0, {tag, "_e0"});
      cyc(sw, e, ox, oe, 1'b0, 1'b0, {tag, "_e1"});
      for (int k = 2; k <= 4; k++) cyc(sw, e, ox, oe, 1'b0, 1'b1, {tag, "_busy"});
      cyc(sw, e, sw, e, 1'b1, 1'b0, {tag, "_e5"});
      cyc(sw, e, sw, e, 1'b0, 1'b0, {tag, "_e6"});
`endif
   endtask
   initial begin
      logic [7:0] pat [12];
      logic [11:0] bpat;
      pat  = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00,
               8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00};
      bpat = 12'b0111_0001_1100;
      // Reset held with all switches high: outputs stay cleared.
      for (int k = 0; k < 3; k++) cyc(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "t1_in_reset");
      rst_n = 1'b1;
      xition(8'hFF, 1'b1, 8'h00, 1'b0, "t1_release");
      xition(8'h00, 1'b0, 8'hFF, 1'b1, "t1_fall");
`ifdef SW_DEBOUNCE_BYPASS_EN
      xition(8'hA5, 1'b0, 8'h00, 1'b0, "t6_bypass");
      xition(8'h00, 1'b0, 8'hA5, 1'b0, "t6_back");
`else
      xition(8'h10, 1'b0, 8'h00, 1'b0, "t2_rise");
      xition(8'h00, 1'b0, 8'h10, 1'b0, "t2_fall");
      // Three-cycle pulses on sw[3] are one short of acceptance.
      for (int k = 0; k < 12; k++) cyc(pat[k], 1'b0, 8'h00, 1'b0, 1'b0, bpat[k], "t3_glitch");
      for (int k = 0; k < 3; k++) cyc(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t3_settle");
      xition(8'h01, 1'b1, 8'h00, 1'b0, "t4_pair");
      xition(8'h00, 1'b0, 8'h01, 1'b1, "t4_back");
      cyc(8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t5_sync0");
      cyc(8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t5_sync1");
      cyc(8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t5_cnt1");
      cyc(8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "t5_cnt2");
      rst_n = 1'b0;
      #1;
      chk("t5_async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t5_in_reset");
      cyc(8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, "t5_in_reset");
      rst_n = 1'b1;
      xition(8'h80, 1'b0, 8'h00, 1'b0, "t5_release");
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
